alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle control and register-file stage that sits directly in front of the 16-bit ALU.
- Accepts one 16-bit instruction per valid/ready handshake and reads two source registers from an internal 8x16 register file.
- Drives the ALU operands and 2-bit op code, captures the ALU result and writes it back to the register file.
- Also provides an immediate-load path that bypasses the ALU, and a debug read port.

Parameters:
- NREGS, 8, number of 16-bit registers. Fixed at 8 because the instruction register fields are 3 bits wide.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction present on instr
- instr_ready  output  1  block can accept an instruction; high only in IDLE
- instr  input  16  instruction word
- alu_a  output  16  ALU operand A
- alu_b  output  16  ALU operand B
- alu_op  output  2  ALU op: 00 ADD, 01 SUB, 10 NAND, 11 no-op
- alu_result  input  16  ALU result (combinational from alu_a/alu_b/alu_op)
- done  output  1  one-cycle pulse when an instruction retires
- zero  output  1  set if the last written-back value was 0
- dbg_sel  input  3  debug register index
- dbg_data  output  16  combinational read of register dbg_sel

Behaviour:
- Reset is asynchronous and active-low; the block has one clock, clk.
- Reset values:
  - state IDLE
  - all registers RESET_VAL
  - alu_a = 0, alu_b = 0, alu_op = 2'b11
  - done = 0, zero = 0
  - latched instruction = 0
- Instruction format:
  - [15:14] opcode
  - [13:11] rd
  - [10:8] rs
  - [7:5] rt
  - [4:0] ignored
  - Opcode 11 is LDI: rd <- {8'h00, instr[7:0]}; rs and rt are ignored.
- R0 reads as 0. Writes to R0 are discarded; the zero flag is still updated.
- State machine, one state per cycle:
  - IDLE: instr_ready = 1. If instr_valid is high, latch instr on the clock edge and go to DECODE. Otherwise stay in IDLE; no state changes.
  - DECODE: register alu_a <= R[rs], alu_b <= R[rt]. Register alu_op <= opcode for 00/01/10, or 11 for LDI. Go to EXEC.
  - EXEC: the ALU evaluates; capture res_q <= alu_result. For LDI, res_q <= zero-extended imm8 and alu_result is never sampled, because the ALU drives Z for op 11. Go to WB.
  - WB: write res_q to R[rd] unless rd = 0. zero <= (res_q == 0). Register done <= 1. Register alu_op <= 2'b11. Go to IDLE.
- Timing:
  - done is high for exactly the one cycle after the WB edge, i.e. the first IDLE cycle.
  - If instr_valid is already high in that cycle, the next instruction is accepted on the same edge that clears done.
  - Throughput is one instruction per 4 cycles.
  - Latency: accept edge E0, operands latched at E1, result captured at E2, register write, zero and done set at E3.
- alu_a and alu_b hold their last values outside DECODE; alu_op is 11 except from the DECODE edge through the WB edge.
- Arithmetic is 16-bit with wrap-around: ADD overflow is discarded, and SUB below zero wraps as two's complement. No carry or overflow flags.
- Hazards: DECODE always follows the previous WB edge, so a read-after-write is satisfied without forwarding.
- instr is sampled only on the accept edge; changes to it afterwards are ignored.
- Reset mid-operation (any state) returns immediately to the reset values. A pending write is lost and done is not pulsed.
- dbg_data reads the current register contents; a write becomes visible the cycle after the WB edge.

Test Plan:
- Reset, then dbg_sel 0..7 -> all dbg_data = 0; instr_ready = 1, alu_op = 11, done = 0, zero = 0.
- LDI R1,0x05; LDI R2,0x03; ADD R3,R1,R2 -> R3 = 0x0008, zero = 0. Check done pulses once per instruction, 4 cycles after each accept.
- SUB R4,R2,R1 -> R4 = 0xFFFE. SUB R5,R1,R1 -> R5 = 0, zero = 1. LDI R6,0xFF; ADD R7,R6,R6 -> 0x01FE.
- NAND R3,R6,R6 with R6 = 0x00FF -> R3 = 0xFF00. ADD R0,R1,R2 -> R0 still reads 0 and zero = 0.
- Throughput and stall: hold instr_valid high with 3 queued instructions -> instr_ready high one cycle in every four, done pulses spaced 4 cycles apart. Drop instr_valid for 5 cycles -> state stays IDLE and no done pulse.
- Reset mid-op: assert rst_n = 0 during EXEC of ADD R3 -> R3 unchanged (0 after reset), no done pulse, and alu_op = 11 immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequencer and 8x16 register file in front of a combinational 16-bit ALU.
// Each instruction goes through IDLE -> DECODE -> EXEC -> WB, so one retires every 4 cycles.
module alu_sequencer #(
  parameter int          NREGS     = 8,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        done,
  output logic        zero,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  localparam logic [1:0] OP_LDI = 2'b11;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic [1:0]  state;
  logic [15:0] instr_q;
  logic [15:0] res_q;
  logic [15:0] regs [NREGS];

  logic [1:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [2:0] rt;

  assign opcode = instr_q[15:14];
  assign rd     = instr_q[13:11];
  assign rs     = instr_q[10:8];
  assign rt     = instr_q[7:5];

  // R0 is hard-wired to zero on every read path, whatever RESET_VAL holds.
  function automatic logic [15:0] read_reg(input logic [2:0] idx);
    return (idx == 3'd0) ? 16'h0000 : regs[idx];
  endfunction

  assign instr_ready = (state == IDLE);
  assign dbg_data    = read_reg(dbg_sel);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      instr_q <= '0;
      res_q   <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= OP_NOP;
      done    <= 1'b0;
      zero    <= 1'b0;
      // NOTE: the register file is small and architecturally defined at reset,
      // so it is reset like ordinary flops rather than left as uninitialised RAM.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= DECODE;
          end
        end
        DECODE: begin
          alu_a  <= read_reg(rs);
          alu_b  <= read_reg(rt);
          alu_op <= opcode;
          state  <= EXEC;
        end
        EXEC: begin
          // The ALU floats its output for op 11, so LDI never samples it.
          res_q <= (opcode == OP_LDI) ? {8'h00, instr_q[7:0]} : alu_result;
          state <= WB;
        end
        WB: begin
          if (rd != 3'd0) begin
            regs[rd] <= res_q;
          end
          zero   <= (res_q == 16'h0000);
          done   <= 1'b1;
          alu_op <= OP_NOP;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
